// File: rtl/lsu_split_ctrl.sv
// Load/store unit front end: turns one core request into one or two word-aligned memory beats,
// merging split load returns into an aligned, extended result.
module lsu_split_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   r0_q;
    logic [XLEN-1:0]   r1_q;
    logic [XLEN-1:0]   resp_data_q;

    logic [2:0]        size_s;
    logic [1:0]        off_s;
    logic              split_s;
    logic [3:0]        byte_mask_s;
    logic [7:0]        lane_mask_s;
    logic [2*XLEN-1:0] lane_data_s;
    logic [XLEN-1:0]   beat0_addr_s;
    logic [XLEN-1:0]   beat1_addr_s;

    // Shift the two-word window down by the byte offset, then extend according to funct3.
    function automatic logic [31:0] load_result(input logic [31:0] lo, input logic [31:0] hi,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] t;
        t = 32'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'b000:  load_result = {{24{t[7]}}, t[7:0]};
            3'b001:  load_result = {{16{t[15]}}, t[15:0]};
            3'b100:  load_result = {24'h000000, t[7:0]};
            3'b101:  load_result = {16'h0000, t[15:0]};
            default: load_result = t;
        endcase
    endfunction

    // Access size: unknown store widths fall back to a full word.
    always_comb begin
        size_s = 3'd4;
        if (we_q) begin
            case (funct3_q)
                3'b000:  size_s = 3'd1;
                3'b001:  size_s = 3'd2;
                default: size_s = 3'd4;
            endcase
        end else begin
            case (funct3_q[1:0])
                2'b00:   size_s = 3'd1;
                2'b01:   size_s = 3'd2;
                default: size_s = 3'd4;
            endcase
        end
        case (size_s)
            3'd1:    byte_mask_s = 4'b0001;
            3'd2:    byte_mask_s = 4'b0011;
            default: byte_mask_s = 4'b1111;
        endcase
    end

    assign off_s        = addr_q[1:0];
    assign split_s      = ({2'b00, off_s} + {1'b0, size_s}) > 4'd4;
    assign lane_mask_s  = {4'b0000, byte_mask_s} << off_s;
    assign lane_data_s  = {{XLEN{1'b0}}, wdata_q} << {off_s, 3'b000};
    assign beat0_addr_s = {addr_q[XLEN-1:2], 2'b00};
    assign beat1_addr_s = beat0_addr_s + 32'd4;

    // Beat outputs decode straight from the state and latched request, so they stay stable while stalled.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_wmask = 4'b0000;
        mem_addr  = beat0_addr_s;
        mem_wdata = {XLEN{1'b0}};
        if (state_q == S_REQ0) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_wmask = we_q ? lane_mask_s[3:0] : 4'b0000;
            mem_wdata = we_q ? lane_data_s[XLEN-1:0] : {XLEN{1'b0}};
        end else if (state_q == S_REQ1) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = beat1_addr_s;
            mem_wmask = we_q ? lane_mask_s[7:4] : 4'b0000;
            mem_wdata = we_q ? lane_data_s[2*XLEN-1:XLEN] : {XLEN{1'b0}};
        end else begin
            mem_valid = 1'b0;
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = resp_data_q;

    // Transaction sequencer; read returns are only taken in the WAIT states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= {XLEN{1'b0}};
            wdata_q     <= {XLEN{1'b0}};
            r0_q        <= {XLEN{1'b0}};
            r1_q        <= {XLEN{1'b0}};
            resp_data_q <= {XLEN{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        r0_q     <= {XLEN{1'b0}};
                        r1_q     <= {XLEN{1'b0}};
                        state_q  <= S_REQ0;
                    end
                end
                S_REQ0: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            state_q <= S_WAIT0;
                        end else if (split_s) begin
                            state_q <= S_REQ1;
                        end else begin
                            resp_data_q <= {XLEN{1'b0}};
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        r0_q <= mem_rdata;
                        if (split_s) begin
                            state_q <= S_REQ1;
                        end else begin
                            resp_data_q <= load_result(mem_rdata, 32'h0000_0000, funct3_q, off_s);
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            resp_data_q <= {XLEN{1'b0}};
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_WAIT1;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        r1_q        <= mem_rdata;
                        resp_data_q <= load_result(r0_q, mem_rdata, funct3_q, off_s);
                        state_q     <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_split_ctrl.md
LSU_SPLIT_CTRL -- requirements
Module: lsu_split_ctrl

Interface
REQ-001 Parameter: XLEN, 32, data/address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  block accepts a request; a transfer happens on req_valid && req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  XLEN  byte address, any alignment.
REQ-009 req_wdata  input  XLEN  store data, right-justified.
REQ-010 mem_valid  output  1  memory beat request.
REQ-011 mem_ready  input  1  memory accepts the beat on mem_valid && mem_ready.
REQ-012 mem_we / mem_wmask / mem_addr / mem_wdata  output  1/4/XLEN/XLEN  beat write enable, byte mask, word-aligned address, lane-positioned data.
REQ-013 mem_rvalid / mem_rdata  input  1/XLEN  read data return, one per accepted read beat.
REQ-014 resp_valid  output  1  one-cycle completion pulse.
REQ-015 resp_data  output  XLEN  aligned, extended load result; 0 for stores.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; state changes on rising clk only.
REQ-018 req_ready = 1 only in IDLE; on acceptance, latch we, funct3, addr, wdata and go to REQ0.
REQ-019 Size: funct3[1:0] 00 = 1 byte, 01 = 2 bytes, else 4 bytes; off = addr[1:0].
REQ-020 split = (off + size - 1) > 3; beat0 addr = {addr[31:2],2'b00}; beat1 addr = beat0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-021 REQ0/REQ1 drive mem_valid = 1 with stable addr/we/mask/data until mem_ready; no other cycle drives mem_valid.
REQ-022 Store beat0: wmask = bytes off..min(off+size-1,3); wdata = req_wdata << 8*off. Store beat1: wmask = low (off+size-4) bytes; wdata = req_wdata >> 8*(4-off).
REQ-023 Loads: wmask = 4'b0000 and mem_we = 0 on every beat.
REQ-024 Store handshake in REQ0: go to REQ1 if split, else RESP; store handshake in REQ1: go to RESP. Stores never enter WAIT states.
REQ-025 Load handshake in REQ0: go to WAIT0; WAIT0 on mem_rvalid: capture r0, then go to REQ1 if split, else RESP.
REQ-026 Load handshake in REQ1: go to WAIT1; WAIT1 on mem_rvalid: capture r1 and go to RESP.
REQ-027 mem_rvalid outside WAIT0/WAIT1 is ignored; mem_rvalid in the same cycle as the request handshake is not accepted.
REQ-028 Load result: t = {r1,r0} >> 8*off (r1 = 0 if not split); LB/LH sign-extend t[7:0]/t[15:0]; LBU/LHU zero-extend; all other funct3 values return t[31:0].
REQ-029 RESP: resp_valid = 1 and resp_data registered, for exactly one cycle; then go to IDLE; resp_data holds its value until the next RESP.
REQ-030 Latency, aligned load with zero-wait memory: accept cycle T; beat handshake T+1; rvalid T+2; resp_valid T+3. A split load adds 2 cycles; an aligned store gives resp_valid at T+2.
REQ-031 Store funct3 values other than SB/SH are treated as SW.

Reset
REQ-032 rst in any state, including mid-transaction: next state IDLE; mem_valid, resp_valid, busy = 0; resp_data and captured words = 0; req_ready = 0 while rst is high and 1 on the first cycle after rst falls.
REQ-033 A mem_rvalid arriving after a reset that aborted a transaction is ignored.

Verification
REQ-034 LW addr 0x100, mem returns 0xDEADBEEF -> one beat at 0x100, resp_data 0xDEADBEEF at T+3.
REQ-035 LH addr 0x103, beat0 rdata 0x80FFFFFF, beat1 rdata 0x000000AB -> beats at 0x100 and 0x104, resp_data 0xFFFFAB80.
REQ-036 SW addr 0x202, wdata 0x11223344 -> beat0 0x200 mask 1100 data 0x33440000; beat1 0x204 mask 0011 data 0x00001122; one resp_valid.
REQ-037 LBU addr 0x7, rdata 0x9A000000, mem_ready low for 3 cycles -> mem_valid and address held stable for 4 cycles, resp_data 0x0000009A.
REQ-038 LW addr 0xFFFFFFFE split -> beat1 address 0x00000000.
REQ-039 rst asserted in WAIT1, then stray mem_rvalid -> no resp_valid; IDLE; req_ready 1 after rst falls.
